// File: rtl/spi_word_if.sv
// spi_word_if: handshake and SPI pin bundle for spi_word_master
// master: the SPI block (drives tx_ready/busy/done/cs_n/sck/mosi); slave: the word source and SPI pins side.
// SPI_READBACK_EN adds miso, rx_data and rx_valid.
interface spi_word_if #(
  parameter int WORD_W = 16
);
  logic [WORD_W-1:0] tx_data;
  logic tx_valid, tx_ready, busy, done, cs_n, sck, mosi;
`ifdef SPI_READBACK_EN
  logic miso, rx_valid;
  logic [WORD_W-1:0] rx_data;
  modport master (input tx_data, tx_valid, miso, output tx_ready, busy, done, cs_n, sck, mosi, rx_data, rx_valid);
  modport slave (output tx_data, tx_valid, miso, input tx_ready, busy, done, cs_n, sck, mosi, rx_data, rx_valid);
`else
  modport master (input tx_data, tx_valid, output tx_ready, busy, done, cs_n, sck, mosi);
  modport slave (output tx_data, tx_valid, input tx_ready, busy, done, cs_n, sck, mosi);
`endif
endinterface

// File: rtl/spi_word_master.sv
// spi_word_master: parametrised mode-0 MSB-first SPI word transmitter with valid/ready input
// Ports: clk; res (async, active-low); bus (spi_word_if.master): tx_data/tx_valid/tx_ready handshake,
// busy, done pulse, cs_n/sck/mosi pins. Optional macro SPI_READBACK_EN adds miso in, rx_data/rx_valid out.
module spi_word_master #(
  parameter int WORD_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input logic clk,
  input logic res,
  spi_word_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2, GAP = 2'd3;
  localparam int CMAX = CLK_DIV > CS_GAP ? CLK_DIV : CS_GAP;
  localparam int CW = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int BW = $clog2(WORD_W);
  logic [1:0] st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d;
  logic rdy_q, rdy_d, busy_q, busy_d, done_q, done_d;
  logic acc, div_last, gap_last;
  assign acc = bus.tx_valid & rdy_q;
  assign div_last = cnt_q == CW'(CLK_DIV - 1);
  assign gap_last = cnt_q == CW'(CS_GAP - 1);
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d = sh_q;
    cs_n_d = cs_n_q;
    sck_d = sck_q;
    mosi_d = mosi_q;
    rdy_d = rdy_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (st_q)
      IDLE: begin
        rdy_d = !acc;
        if (acc) begin
          st_d = SHIFT;
          cnt_d = '0;
          bit_d = BW'(WORD_W - 1);
          sh_d = bus.tx_data;
          mosi_d = bus.tx_data[WORD_W-1];
          cs_n_d = 1'b0;
          busy_d = 1'b1;
        end
      end
      SHIFT: begin
        cnt_d = div_last ? '0 : cnt_q + 1'b1;
        if (div_last) begin
          sck_d = !sck_q;
          // end of a high phase: advance to the next bit on the falling edge, or finish after bit 0
          if (sck_q) begin
            st_d = bit_q == '0 ? HOLD : SHIFT;
            mosi_d = bit_q == '0 ? 1'b0 : sh_q[WORD_W-2];
            bit_d = bit_q == '0 ? bit_q : bit_q - 1'b1;
            sh_d = sh_q << 1;
          end
        end
      end
      HOLD: begin
        cnt_d = div_last ? '0 : cnt_q + 1'b1;
        st_d = div_last ? GAP : HOLD;
        cs_n_d = div_last;
        done_d = div_last;
      end
      default: begin
        cnt_d = gap_last ? '0 : cnt_q + 1'b1;
        st_d = gap_last ? IDLE : GAP;
        busy_d = !gap_last;
        rdy_d = gap_last;
      end
    endcase
  end
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      st_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      cs_n_q <= 1'b1;
      sck_q <= 1'b0;
      mosi_q <= 1'b0;
      rdy_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      cs_n_q <= cs_n_d;
      sck_q <= sck_d;
      mosi_q <= mosi_d;
      rdy_q <= rdy_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign bus.tx_ready = rdy_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.cs_n = cs_n_q;
  assign bus.sck = sck_q;
  assign bus.mosi = mosi_q;
`ifdef SPI_READBACK_EN
  logic [WORD_W-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic rx_valid_q;
  // miso is captured on the edge where sck rises, i.e. at the end of a low phase
  always_comb begin
    rx_sh_d = (st_q == SHIFT && div_last && !sck_q) ? {rx_sh_q[WORD_W-2:0], bus.miso} : rx_sh_q;
    rx_data_d = done_d ? rx_sh_q : rx_data_q;
  end
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      rx_sh_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= done_d;
    end
  assign bus.rx_data = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`endif
endmodule

// File: tb/tb_spi_word_master.sv
// tb_spi_word_master: table, corner-case and random checks of spi_word_master against spec-level expectations
module tb_spi_word_master;
  logic clk = 1'b0;
  logic res;
  int checks = 0;
  int errors = 0;
  spi_word_if #(.WORD_W(16)) if16 ();
  spi_word_if #(.WORD_W(8)) if8 ();
  spi_word_master #(.WORD_W(16), .CLK_DIV(2), .CS_GAP(4)) dut16 (.clk(clk), .res(res), .bus(if16));
  spi_word_master #(.WORD_W(8), .CLK_DIV(1), .CS_GAP(1)) dut8 (.clk(clk), .res(res), .bus(if8));
`ifdef SPI_READBACK_EN
  assign if16.miso = if16.mosi;
  assign if8.miso = if8.mosi;
`endif
  always #5 clk = ~clk;

  typedef struct packed {logic cs_n, sck, mosi, done, rdy, busy;} ob_t;
  typedef struct {
    int sel;
    logic [31:0] word, alt;
    bit hold;
    int low, rise, gap;
  } vec_t;

  logic [31:0] sent [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ob_t obs(input int sel);
    ob_t r;
    r = sel != 0 ? {if8.cs_n, if8.sck, if8.mosi, if8.done, if8.tx_ready, if8.busy}
                 : {if16.cs_n, if16.sck, if16.mosi, if16.done, if16.tx_ready, if16.busy};
    return r;
  endfunction

  task automatic drv(input int sel, input bit v, input logic [31:0] d);
    if (sel != 0) begin
      if8.tx_valid = v;
      if8.tx_data = d[7:0];
    end else begin
      if16.tx_valid = v;
      if16.tx_data = d[15:0];
    end
  endtask

  task automatic wait_rdy(input int sel);
    ob_t o;
    o = obs(sel);
    for (int n = 0; n < 300 && !o.rdy; n++) begin
      @(negedge clk);
      o = obs(sel);
    end
    chk("ready_wait", o.rdy, 1);
  endtask

  task automatic idle_check(input int sel, input int cycles);
    ob_t o;
    int bad = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      o = obs(sel);
      if (!o.cs_n || o.busy || o.done || !o.rdy) bad++;
    end
    chk("idle_no_retx", bad, 0);
  endtask

  // Observes one word from accept to the return of tx_ready; exp values come from the spec formulas.
  task automatic mon(input int sel, input int w, input int exp_low, input int exp_rise, input int exp_gap,
                     input bit hold, input logic [31:0] alt, output int pre);
    ob_t o, p;
    logic [31:0] word, bits;
    int low, rises, bad, dones, gap, n;
    word = sent.size() > 0 ? sent.pop_front() : 32'hDEAD;
    if (hold) sent.push_back(alt);
    o = obs(sel);
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      o = obs(sel);
      if (!o.cs_n) break;
    end
    pre = n;
    chk("start", o.cs_n, 0);
    if (o.cs_n) return;
    drv(sel, hold, alt);
    chk("accept", {o.sck, o.mosi, o.busy, o.rdy, o.done}, {1'b0, word[w-1], 1'b1, 1'b0, 1'b0});
    bits = 0;
    low = 1;
    rises = 0;
    bad = 0;
    dones = 0;
    p = o;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk);
      o = obs(sel);
      if (o.cs_n) break;
      low++;
      if (!p.sck && o.sck) begin
        bits = {bits[30:0], o.mosi};
        rises++;
      end
      if (o.mosi != p.mosi && !(p.sck && !o.sck)) bad++;
      if (o.done) dones++;
      p = o;
    end
    chk("cs_low", low, exp_low);
    chk("sck_rises", rises, exp_rise);
    chk("bits", bits, word & ((32'd1 << w) - 1));
    chk("mosi_timing", bad, 0);
    chk("done_early", dones, 0);
    chk("cs_rise", {o.cs_n, o.sck, o.mosi, o.done, o.busy, o.rdy}, 6'b100110);
`ifdef SPI_READBACK_EN
    chk("rx_valid", sel != 0 ? if8.rx_valid : if16.rx_valid, 1);
    chk("rx_data", sel != 0 ? 32'(if8.rx_data) : 32'(if16.rx_data), word);
`endif
    gap = 0;
    bad = 0;
    for (n = 0; n < 300 && !o.rdy; n++) begin
      gap++;
      @(negedge clk);
      o = obs(sel);
      if (!o.rdy && (!o.cs_n || !o.busy)) bad++;
      if (o.done) bad++;
`ifdef SPI_READBACK_EN
      if (sel != 0 ? if8.rx_valid : if16.rx_valid) bad++;
`endif
    end
    chk("gap", gap, exp_gap);
    chk("gap_state", bad, 0);
    chk("ready", {o.rdy, o.busy, o.done, o.cs_n}, 4'b1001);
  endtask

  initial begin
    vec_t v [8];
    ob_t o, p;
    int pre, rises, sel, w;
    bit chained, hold;
    logic [31:0] word, alt;
    v[0] = '{0, 32'h0C01, 32'h0000, 1'b0, 66, 16, 4};
    v[1] = '{0, 32'h09FF, 32'h0105, 1'b1, 66, 16, 4};
    v[2] = '{0, 32'h0105, 32'h0000, 1'b0, 66, 16, 4};
    v[3] = '{0, 32'h1234, 32'hFFFF, 1'b0, 66, 16, 4};
    v[4] = '{1, 32'h00A5, 32'h005A, 1'b0, 17, 8, 1};
    v[5] = '{1, 32'h00C3, 32'h00FF, 1'b1, 17, 8, 1};
    v[6] = '{1, 32'h00FF, 32'h0000, 1'b0, 17, 8, 1};
    v[7] = '{0, 32'h8000, 32'h7FFF, 1'b0, 66, 16, 4};
    res = 1'b0;
    drv(0, 1'b0, 0);
    drv(1, 1'b0, 0);
    repeat (3) @(negedge clk);
    o = obs(0);
    chk("reset_state16", o, 6'b100000);
    o = obs(1);
    chk("reset_state8", o, 6'b100000);
    res = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {obs(0).rdy, obs(1).rdy}, 2'b11);

    chained = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!chained) begin
        wait_rdy(v[i].sel);
        drv(v[i].sel, 1'b1, v[i].word);
        sent.push_back(v[i].word);
      end
      mon(v[i].sel, v[i].sel != 0 ? 8 : 16, v[i].low, v[i].rise, v[i].gap, v[i].hold, v[i].alt, pre);
      if (chained) chk("held_accept", pre, 0);
      if (!v[i].hold) idle_check(v[i].sel, 6);
      chained = v[i].hold;
    end

    // abort a word with res after the 5th sck rise
    wait_rdy(0);
    drv(0, 1'b1, 32'h0F0F);
    rises = 0;
    p = obs(0);
    for (int n = 0; n < 300 && rises < 5; n++) begin
      @(negedge clk);
      o = obs(0);
      if (!o.cs_n) drv(0, 1'b0, 0);
      if (!p.sck && o.sck) rises++;
      p = o;
    end
    chk("pre_reset_rises", rises, 5);
    #1 res = 1'b0;
    #1 o = obs(0);
    chk("async_reset", o, 6'b100000);
`ifdef SPI_READBACK_EN
    chk("rx_reset", {if16.rx_valid, if16.rx_data}, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    res = 1'b1;
    @(negedge clk);
    o = obs(0);
    chk("ready_after_abort", {o.rdy, o.cs_n, o.done, o.busy}, 4'b1100);
    drv(0, 1'b1, 32'h0301);
    sent.push_back(32'h0301);
    mon(0, 16, 66, 16, 4, 1'b0, 32'h0000, pre);

    // random words, random idle time and random back-to-back chains
    chained = 1'b0;
    sel = 0;
    word = 0;
    for (int i = 0; i < 24; i++) begin
      if (!chained) begin
        sel = int'($urandom_range(0, 1));
        word = $urandom & (sel != 0 ? 32'hFF : 32'hFFFF);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        wait_rdy(sel);
        drv(sel, 1'b1, word);
        sent.push_back(word);
      end
      hold = (i < 23) && ($urandom_range(0, 2) == 0);
      alt = $urandom & (sel != 0 ? 32'hFF : 32'hFFFF);
      w = sel != 0 ? 8 : 16;
      mon(sel, w, (sel != 0 ? 1 : 2) * (2 * w + 1), w, sel != 0 ? 1 : 4, hold, alt, pre);
      if (chained) chk("rand_held_accept", pre, 0);
      chained = hold;
    end
    idle_check(sel, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
